// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - two-lane TDM receive demultiplexer with sync hunt and truncation count
module tdm_demux #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             sync,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             valid,
  output logic             lane,
  output logic             frame_err,
  output logic [7:0]       err_cnt
);

  localparam int CW = $clog2(2 * WIDTH);
  localparam logic [CW-1:0] LAST = CW'(2 * WIDTH - 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [CW-2:0]   idx;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic            start, cap, last, err;

  assign idx = cnt[CW-1:1];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    start     = 1'b0;
    cap       = 1'b0;
    last      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (sync) begin
          start     = 1'b1;
          cnt_nxt   = CW'(1);
          state_nxt = RECV;
        end
      end
      RECV: begin
        if (sync) begin
          // early sync: current bit becomes a0 of a fresh frame
          err     = 1'b1;
          start   = 1'b1;
          cnt_nxt = CW'(1);
        end else if (cnt == LAST) begin
          last      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cap     = 1'b1;
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      sh_a      <= '0;
      sh_b      <= '0;
      out_a     <= '0;
      out_b     <= '0;
      valid     <= 1'b0;
      lane      <= 1'b0;
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      lane      <= (state_nxt == RECV) ? cnt_nxt[0] : 1'b0;
      valid     <= last;
      frame_err <= err;
      if (err && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
      if (start) begin
        sh_a <= WIDTH'(din);
        sh_b <= '0;
      end else if (cap) begin
        if (cnt[0])
          sh_b[idx] <= din;
        else
          sh_a[idx] <= din;
      end
      // b(W-1) arrives on this edge, so it bypasses the shift register
      if (last) begin
        out_a <= sh_a;
        out_b <= sh_b | {din, {(WIDTH-1){1'b0}}};
      end
    end
  end

endmodule
